// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the pipeline control decoder.
// Contents:
//   - opcode constants for the supported instruction classes
//   - funct3/funct7 constants used by the byte-access and ALU decode
//   - aluop_t      : 2-bit ALU operation class from the main decoder
//   - alu_ctrl_t   : 3-bit ALU operation driven to the E stage
//   - e/m/w_ctrl_t : control bits carried in each stage register
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // LB/SB; every other funct3 on a load/store is treated as a word access
  localparam logic [2:0] F3_BYTE = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010
  } alu_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    logic      memwrite;
    logic      memtoreg;
    logic      byte_acc;
    logic      alusrc;
    alu_ctrl_t alu_ctrl;
  } e_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic byte_acc;
  } m_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic byte_acc;
  } w_ctrl_t;

endpackage

// File: rtl/pipe_control_decoder_if.sv
// Signal bundle between the datapath and the pipeline control decoder.
// Flow control: there is no valid/ready pair. ihit and dhit act as the only
// handshake: when either is low the control pipeline freezes (no stage
// register updates) and resumes on the first rising clock edge where both
// are high. Opcode/funct fields belong to the instruction currently in D.
//   master : datapath side  (drives ihit/dhit/opcode/funct3/funct7)
//   slave  : decoder side   (drives all control outputs)
interface pipe_control_decoder_if;

  logic       ihit;
  logic       dhit;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       RegWrite;
  logic       MemWrite;
  logic       MemWriteD;
  logic       LoadD;
  logic       BranchD;
  logic       JumpD;
  logic       ByteD;
  logic       ALUSrcE;
  logic       ByteW;
  logic       MemtoRegW;
  logic [2:0] ALUControl;

  modport master (
    output ihit, dhit, opcode, funct3, funct7,
    input  RegWrite, MemWrite, MemWriteD, LoadD, BranchD, JumpD, ByteD,
    input  ALUSrcE, ByteW, MemtoRegW, ALUControl
  );

  modport slave (
    input  ihit, dhit, opcode, funct3, funct7,
    output RegWrite, MemWrite, MemWriteD, LoadD, BranchD, JumpD, ByteD,
    output ALUSrcE, ByteW, MemtoRegW, ALUControl
  );

endinterface

// File: rtl/alu_op_decode.sv
// ALU operation decode: maps the main decoder's aluop class plus funct7
// to the 3-bit ALU operation. Purely combinational.
// Ports:
//   aluop    in  2  operation class (ADD / SUB / decode funct7)
//   funct7   in  7  instruction bits [31:25]
//   alu_ctrl out 3  ALU operation (ADD=000, SUB=001, MUL=010)
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [6:0] funct7,
  output alu_ctrl_t  alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        // unknown funct7 values fall back to ADD rather than a reserved code
        case (funct7)
          F7_SUB:  alu_ctrl = ALU_SUB;
          F7_MUL:  alu_ctrl = ALU_MUL;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/pipe_control_decoder.sv
// Control unit for a 5-stage RISC-V pipeline. Decodes the D-stage
// instruction and carries the control bits through E, M and W stage
// registers; each output is presented in the stage that consumes it.
// Ports:
//   clk    in  pipeline clock, stage registers update on rising edge
//   reset  in  asynchronous active-high clear of all stage registers
//   bus    slave side of pipe_control_decoder_if:
//          ihit/dhit      cache hits, either low freezes the pipeline
//          opcode/funct3/funct7  D-stage instruction fields
//          MemWriteD, LoadD, BranchD, JumpD, ByteD  D-stage flags
//          ALUSrcE, ALUControl                      E-stage controls
//          MemWrite                                 M-stage store request
//          RegWrite, MemtoRegW, ByteW               W-stage controls
module pipe_control_decoder
  import riscv_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  pipe_control_decoder_if.slave bus
);

  logic      stall;
  logic      regwrite_d;
  logic      memwrite_d;
  logic      memtoreg_d;
  logic      load_d;
  logic      branch_d;
  logic      jump_d;
  logic      byte_d;
  logic      alusrc_d;
  aluop_t    aluop_d;
  alu_ctrl_t alu_ctrl_d;

  e_ctrl_t e_q;
  m_ctrl_t m_q;
  w_ctrl_t w_q;

  assign stall = ~bus.ihit | ~bus.dhit;

  // Main decode; unsupported opcodes (including the all-zero bubble the
  // datapath injects on flush) decode to all-zero controls.
  always_comb begin
    regwrite_d = 1'b0;
    memwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    load_d     = 1'b0;
    branch_d   = 1'b0;
    jump_d     = 1'b0;
    alusrc_d   = 1'b0;
    aluop_d    = ALUOP_ADD;
    case (bus.opcode)
      OP_RTYPE: begin
        regwrite_d = 1'b1;
        aluop_d    = ALUOP_FUNCT;
      end
      OP_ADDI: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
      end
      OP_LOAD: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        load_d     = 1'b1;
        memtoreg_d = 1'b1;
      end
      OP_STORE: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
      end
      OP_BEQ: begin
        branch_d = 1'b1;
        aluop_d  = ALUOP_SUB;
      end
      OP_JAL: begin
        regwrite_d = 1'b1;
        jump_d     = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_d = (load_d | memwrite_d) & (bus.funct3 == F3_BYTE);

  alu_op_decode u_alu_op_decode (
    .aluop    (aluop_d),
    .funct7   (bus.funct7),
    .alu_ctrl (alu_ctrl_d)
  );

  // Stage registers freeze together with the datapath on any cache miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (!stall) begin
      e_q.regwrite <= regwrite_d;
      e_q.memwrite <= memwrite_d;
      e_q.memtoreg <= memtoreg_d;
      e_q.byte_acc <= byte_d;
      e_q.alusrc   <= alusrc_d;
      e_q.alu_ctrl <= alu_ctrl_d;

      m_q.regwrite <= e_q.regwrite;
      m_q.memwrite <= e_q.memwrite;
      m_q.memtoreg <= e_q.memtoreg;
      m_q.byte_acc <= e_q.byte_acc;

      w_q.regwrite <= m_q.regwrite;
      w_q.memtoreg <= m_q.memtoreg;
      w_q.byte_acc <= m_q.byte_acc;
    end
  end

  // W holds its instruction across a stall; gating the write enable means
  // the register file only commits it on the single non-stalled edge.
  assign bus.RegWrite   = w_q.regwrite & ~stall;
  // The store request must stay up while the D-cache services the miss.
  assign bus.MemWrite   = m_q.memwrite;
  assign bus.MemWriteD  = memwrite_d;
  assign bus.LoadD      = load_d;
  assign bus.BranchD    = branch_d;
  assign bus.JumpD      = jump_d;
  assign bus.ByteD      = byte_d;
  assign bus.ALUSrcE    = e_q.alusrc;
  assign bus.ALUControl = e_q.alu_ctrl;
  assign bus.ByteW      = w_q.byte_acc;
  assign bus.MemtoRegW  = w_q.memtoreg;

endmodule

// File: tb/tb_pipe_control_decoder.sv
// Bench for pipe_control_decoder: directed scenarios plus a random
// back-to-back stream checked against a decode table and stage queues.
module tb_pipe_control_decoder;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] d;  // {MemWriteD, LoadD, BranchD, JumpD, ByteD}
    logic [3:0] e;  // {ALUSrcE, ALUControl}
    logic       m;  // MemWrite
    logic [2:0] w;  // {RegWrite, MemtoRegW, ByteW}
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [3:0] exp_e_q[$];
  logic [0:0] exp_m_q[$];
  logic [2:0] exp_w_q[$];

  pipe_control_decoder_if bus();

  pipe_control_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [4:0] obs_d;
  logic [3:0] obs_e;
  logic [2:0] obs_w;
  logic [7:0] obs_regs;
  assign obs_d    = {bus.MemWriteD, bus.LoadD, bus.BranchD, bus.JumpD, bus.ByteD};
  assign obs_e    = {bus.ALUSrcE, bus.ALUControl};
  assign obs_w    = {bus.RegWrite, bus.MemtoRegW, bus.ByteW};
  assign obs_regs = {bus.ALUSrcE, bus.ALUControl, bus.MemWrite, bus.ByteW,
                     bus.MemtoRegW, bus.RegWrite};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // Clears the pipeline and seeds the M/W queues with the zeros that
  // reset leaves in the later stages.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_e_q.delete();
    exp_m_q.delete();
    exp_w_q.delete();
    exp_m_q.push_back(1'b0);
    exp_w_q.push_back(3'b000);
    exp_w_q.push_back(3'b000);
  endtask

  // Expected controls from the instruction-class table.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7);
    exp_t       x;
    logic [2:0] arith;
    logic       is_byte;
    x       = '0;
    arith   = (f7 == 7'b0100000) ? 3'b001 : (f7 == 7'b0000001) ? 3'b010 : 3'b000;
    is_byte = (f3 == 3'b000);
    case (op)
      7'b0110011: begin x.e = {1'b0, arith}; x.w = 3'b100; end
      7'b0010011: begin x.e = 4'b1000; x.w = 3'b100; end
      7'b0000011: begin x.d = {3'b010, 1'b0, is_byte}; x.e = 4'b1000; x.w = {2'b11, is_byte}; end
      7'b0100011: begin x.d = {4'b1000, is_byte}; x.e = 4'b1000; x.m = 1'b1; x.w = {2'b00, is_byte}; end
      7'b1100011: begin x.d = 5'b00100; x.e = 4'b0001; end
      7'b1101111: begin x.d = 5'b00010; x.e = 4'b0000; x.w = 3'b100; end
      default: ;
    endcase
    return x;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(OP_LOAD, 3'b000, 7'd0);
    step();
    checks++;
    if (obs_regs !== 8'd0) begin
      failures++;
      $display("FAIL reset_hold regs got=%b exp=%b", obs_regs, 8'd0);
    end
    checks++;
    if (bus.LoadD !== 1'b1) begin
      failures++;
      $display("FAIL reset_loadd got=%b exp=1", bus.LoadD);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs_e !== 4'b1000) begin
      failures++;
      $display("FAIL reset_pre_e got=%b exp=1000", obs_e);
    end
    step();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (obs_regs !== 8'd0) begin
      failures++;
      $display("FAIL reset_async regs got=%b exp=%b", obs_regs, 8'd0);
    end
    checks++;
    if (bus.LoadD !== 1'b1) begin
      failures++;
      $display("FAIL reset_async_loadd got=%b exp=1", bus.LoadD);
    end
    step();
    drive(7'd0, 3'b000, 7'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.RegWrite, bus.MemtoRegW} !== 2'b00) begin
        failures++;
        $display("FAIL reset_lost_w[%0d] got=%b exp=00", i, {bus.RegWrite, bus.MemtoRegW});
      end
    end
  endtask

  task automatic test_decode_stream();
    logic [16:0] tbl [0:13];
    exp_t        x;
    logic [3:0]  ee;
    logic [0:0]  em;
    logic [2:0]  ew;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    tbl[0]  = {OP_RTYPE, 3'b000, F7_SUB};
    tbl[1]  = {OP_RTYPE, 3'b000, F7_MUL};
    tbl[2]  = {OP_RTYPE, 3'b111, F7_ADD};
    tbl[3]  = {OP_RTYPE, 3'b000, 7'b1111111};
    tbl[4]  = {OP_ADDI,  3'b000, 7'b0100000};
    tbl[5]  = {OP_LOAD,  3'b000, 7'd0};
    tbl[6]  = {OP_LOAD,  3'b010, 7'd0};
    tbl[7]  = {OP_LOAD,  3'b100, 7'd0};
    tbl[8]  = {OP_STORE, 3'b000, 7'd0};
    tbl[9]  = {OP_STORE, 3'b010, 7'd0};
    tbl[10] = {OP_BEQ,   3'b000, 7'b0000001};
    tbl[11] = {OP_JAL,   3'b000, 7'd0};
    tbl[12] = {7'b1111111, 3'b000, 7'd0};
    tbl[13] = {7'b0000000, 3'b000, 7'd0};
    pulse_reset();
    for (int k = 0; k < 17; k++) begin
      if (k < 14) {op, f3, f7} = tbl[k];
      else {op, f3, f7} = 17'd0;
      drive(op, f3, f7);
      #1;
      x = model(op, f3, f7);
      checks++;
      if (obs_d !== x.d) begin
        failures++;
        $display("FAIL stream_d[%0d] op=%b got=%b exp=%b", k, op, obs_d, x.d);
      end
      exp_e_q.push_back(x.e);
      exp_m_q.push_back(x.m);
      exp_w_q.push_back(x.w);
      step();
      ee = exp_e_q.pop_front();
      em = exp_m_q.pop_front();
      ew = exp_w_q.pop_front();
      checks++;
      if (obs_e !== ee) begin
        failures++;
        $display("FAIL stream_e[%0d] got=%b exp=%b", k, obs_e, ee);
      end
      checks++;
      if (bus.MemWrite !== em) begin
        failures++;
        $display("FAIL stream_m[%0d] got=%b exp=%b", k, bus.MemWrite, em);
      end
      checks++;
      if (obs_w !== ew) begin
        failures++;
        $display("FAIL stream_w[%0d] got=%b exp=%b", k, obs_w, ew);
      end
    end
  endtask

  task automatic test_sw_dmiss();
    pulse_reset();
    drive(OP_ADDI, 3'b000, 7'd0);
    step();
    drive(OP_STORE, 3'b010, 7'd0);
    #1;
    checks++;
    if ({bus.MemWriteD, bus.ByteD} !== 2'b10) begin
      failures++;
      $display("FAIL sw_d got=%b exp=10", {bus.MemWriteD, bus.ByteD});
    end
    step();
    drive(7'd0, 3'b000, 7'd0);
    step();
    checks++;
    if ({bus.MemWrite, bus.RegWrite} !== 2'b11) begin
      failures++;
      $display("FAIL sw_m_pre got=%b exp=11", {bus.MemWrite, bus.RegWrite});
    end
    bus.dhit = 1'b0;
    #1;
    checks++;
    if ({bus.MemWrite, bus.RegWrite} !== 2'b10) begin
      failures++;
      $display("FAIL sw_dmiss_gate got=%b exp=10", {bus.MemWrite, bus.RegWrite});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.MemWrite, bus.RegWrite} !== 2'b10) begin
        failures++;
        $display("FAIL sw_dmiss_hold[%0d] got=%b exp=10", i, {bus.MemWrite, bus.RegWrite});
      end
    end
    bus.dhit = 1'b1;
    #1;
    checks++;
    if (bus.RegWrite !== 1'b1) begin
      failures++;
      $display("FAIL sw_release_rw got=%b exp=1", bus.RegWrite);
    end
    step();
    checks++;
    if ({bus.MemWrite, bus.RegWrite, bus.ByteW} !== 3'b000) begin
      failures++;
      $display("FAIL sw_after got=%b exp=000", {bus.MemWrite, bus.RegWrite, bus.ByteW});
    end
  endtask

  task automatic test_imiss_addi();
    logic [1:0] stall_pat [0:2];
    int         pulses;
    stall_pat[0] = 2'b01;  // {ihit, dhit}
    stall_pat[1] = 2'b00;
    stall_pat[2] = 2'b10;
    pulse_reset();
    drive(OP_ADDI, 3'b000, 7'd0);
    step();
    checks++;
    if (obs_e !== 4'b1000) begin
      failures++;
      $display("FAIL addi_e got=%b exp=1000", obs_e);
    end
    drive(7'd0, 3'b000, 7'd0);
    for (int i = 0; i < 3; i++) begin
      {bus.ihit, bus.dhit} = stall_pat[i];
      step();
      checks++;
      if ({obs_e, bus.RegWrite} !== 5'b10000) begin
        failures++;
        $display("FAIL imiss_hold[%0d] got=%b exp=10000", i, {obs_e, bus.RegWrite});
      end
    end
    {bus.ihit, bus.dhit} = 2'b11;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(bus.RegWrite);
      checks++;
      if (bus.RegWrite !== (i == 1)) begin
        failures++;
        $display("FAIL imiss_rw[%0d] got=%b exp=%b", i, bus.RegWrite, (i == 1));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL imiss_pulses got=%0d exp=1", pulses);
    end
    // illegal opcode arriving during an I-miss
    drive(7'b1111111, 3'b000, 7'd0);
    bus.ihit = 1'b0;
    #1;
    checks++;
    if (obs_d !== 5'b00000) begin
      failures++;
      $display("FAIL illegal_d got=%b exp=00000", obs_d);
    end
    step();
    bus.ihit = 1'b1;
    step();
    drive(7'd0, 3'b000, 7'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.RegWrite !== 1'b0) begin
        failures++;
        $display("FAIL illegal_rw[%0d] got=%b exp=0", i, bus.RegWrite);
      end
    end
  endtask

  task automatic test_stall_reset();
    pulse_reset();
    drive(OP_LOAD, 3'b000, 7'd0);
    step();
    bus.dhit = 1'b0;
    step();
    checks++;
    if (obs_e !== 4'b1000) begin
      failures++;
      $display("FAIL stall_reset_pre got=%b exp=1000", obs_e);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs_regs !== 8'd0) begin
      failures++;
      $display("FAIL stall_reset_clear got=%b exp=%b", obs_regs, 8'd0);
    end
    drive(7'd0, 3'b000, 7'd0);
    #1;
    reset = 1'b0;
    bus.dhit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.RegWrite, bus.MemtoRegW, bus.ByteW} !== 3'b000) begin
        failures++;
        $display("FAIL stall_reset_lost[%0d] got=%b exp=000", i,
                 {bus.RegWrite, bus.MemtoRegW, bus.ByteW});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [0:6];
    logic [6:0] f7s [0:2];
    exp_t       x;
    logic [3:0] ee;
    logic [0:0] em;
    logic [2:0] ew;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         sel;
    ops[0] = OP_RTYPE; ops[1] = OP_ADDI; ops[2] = OP_LOAD; ops[3] = OP_STORE;
    ops[4] = OP_BEQ;   ops[5] = OP_JAL;  ops[6] = 7'b1111111;
    f7s[0] = 7'b0000000; f7s[1] = 7'b0100000; f7s[2] = 7'b0000001;
    pulse_reset();
    for (int k = 0; k < 27; k++) begin
      if (k < 24) begin
        sel = $urandom_range(0, 7);
        op  = (sel == 7) ? 7'($urandom_range(0, 127)) : ops[sel];
        f3  = 3'($urandom_range(0, 7));
        sel = $urandom_range(0, 3);
        f7  = (sel == 3) ? 7'($urandom_range(0, 127)) : f7s[sel];
      end else begin
        op = 7'd0; f3 = 3'd0; f7 = 7'd0;
      end
      drive(op, f3, f7);
      #1;
      x = model(op, f3, f7);
      checks++;
      if (obs_d !== x.d) begin
        failures++;
        $display("FAIL b2b_d[%0d] op=%b f3=%b got=%b exp=%b", k, op, f3, obs_d, x.d);
      end
      exp_e_q.push_back(x.e);
      exp_m_q.push_back(x.m);
      exp_w_q.push_back(x.w);
      step();
      ee = exp_e_q.pop_front();
      em = exp_m_q.pop_front();
      ew = exp_w_q.pop_front();
      checks++;
      if ({obs_e, bus.MemWrite, obs_w} !== {ee, em, ew}) begin
        failures++;
        $display("FAIL b2b_pipe[%0d] got=%b exp=%b", k, {obs_e, bus.MemWrite, obs_w},
                 {ee, em, ew});
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.ihit = 1'b1;
    bus.dhit = 1'b1;
    drive(7'd0, 3'b000, 7'd0);
    test_reset();
    test_decode_stream();
    test_sw_dmiss();
    test_imiss_addi();
    test_stall_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
